// File: rtl/fmc_sys_pkg.sv
// Shared types and constants for the FMC system-side request sequencer.
package fmc_sys_pkg;

  localparam int ADDR_WIDTH_DEF   = 16;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int READ_LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Request word layout: {wr, addr, wdata}
  function automatic int req_width(int aw, int dw);
    return 1 + aw + dw;
  endfunction

  function automatic int wr_bit(int aw, int dw);
    return aw + dw;
  endfunction

  function automatic int addr_lsb(int dw);
    return dw;
  endfunction

endpackage

// File: rtl/fmc_sys_sequencer_if.sv
// Request, system bus and response signals of the sequencer, grouped as one bundle.
interface fmc_sys_sequencer_if
  import fmc_sys_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                         req_valid;
  logic [ADDR_WIDTH+DATA_WIDTH:0] req_data;
  logic [ADDR_WIDTH-1:0]        sys_addr;
  logic                         sys_wr;
  logic                         sys_rd;
  logic [DATA_WIDTH-1:0]        sys_wr_data;
  logic [DATA_WIDTH-1:0]        sys_rd_data;
  logic                         rsp_req;
  logic [DATA_WIDTH-1:0]        rsp_data;
  logic                         busy;
  logic                         overflow;

  modport master (
    input  req_valid, req_data, sys_rd_data,
    output sys_addr, sys_wr, sys_rd, sys_wr_data, rsp_req, rsp_data, busy, overflow
  );

  modport slave (
    output req_valid, req_data, sys_rd_data,
    input  sys_addr, sys_wr, sys_rd, sys_wr_data, rsp_req, rsp_data, busy, overflow
  );
endinterface

// File: rtl/fmc_req_fifo.sv
// Synchronous request FIFO with explicit occupancy count; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module fmc_req_fifo
  import fmc_sys_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fmc_sys_sequencer.sv
// Replays buffered CDC request pulses as single-cycle system bus strobes and
// returns read data as a one-cycle response pulse.
module fmc_sys_sequencer
  import fmc_sys_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic clk,
  input  logic reset_n,
  fmc_sys_sequencer_if.master bus
);

  localparam int REQ_W    = req_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int WR_POS   = wr_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int LAT_W    = $clog2(READ_LATENCY) + 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  rsp_req_q, rsp_req_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  overflow_q, overflow_d;

  logic                  pop_s;
  logic [REQ_W-1:0]      head_s;
  logic                  full_s;
  logic                  empty_s;
  logic [CNT_W-1:0]      count_s;

  fmc_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (bus.req_valid),
    .pop_i   (pop_s),
    .wdata_i (bus.req_data),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // A request is lost only when the FIFO is full and nothing leaves it this cycle
  assign overflow_d = overflow_q | (bus.req_valid & full_s & ~pop_s);

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    rsp_req_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    lat_d      = lat_q;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          addr_d  = head_s[ADDR_LSB +: ADDR_WIDTH];
          wdata_d = head_s[DATA_WIDTH-1:0];
          wr_d    = head_s[WR_POS];
          rd_d    = ~head_s[WR_POS];
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (wr_q) begin
          state_d = ST_IDLE;
        end else begin
          lat_d   = LAT_W'(READ_LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == {LAT_W{1'b0}}) begin
          rsp_data_d = bus.sys_rd_data;
          rsp_req_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= {DATA_WIDTH{1'b0}};
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      rsp_req_q  <= 1'b0;
      rsp_data_q <= {DATA_WIDTH{1'b0}};
      lat_q      <= {LAT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      rsp_req_q  <= rsp_req_d;
      rsp_data_q <= rsp_data_d;
      lat_q      <= lat_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.sys_addr    = addr_q;
  assign bus.sys_wr_data = wdata_q;
  assign bus.sys_wr      = wr_q;
  assign bus.sys_rd      = rd_q;
  assign bus.rsp_req     = rsp_req_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = (state_q != ST_IDLE) || (count_s != {CNT_W{1'b0}});

endmodule

// File: doc/fmc_sys_sequencer.md
Name: fmc_sys_sequencer

Overview:
Destination-clock-domain consumer of the FMC request crossing. It accepts one-cycle request pulses carrying {write flag, address, write data} from the bus-pulse CDC stage, buffers them, and replays each one as a single-cycle read or write strobe on the system bus. For reads it captures the system read data after a fixed latency and emits a one-cycle response pulse with data, to feed the return-path CDC stage.

Parameters:
ADDR_WIDTH, 16, system bus address width
DATA_WIDTH, 32, system bus data width
FIFO_DEPTH, 4, request buffer entries; power of two, minimum 2
READ_LATENCY, 2, cycles from the sys_rd strobe to valid sys_rd_data; minimum 1

Ports:
clk  in  1  system clock; the single clock for all logic
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  one-cycle request pulse from the CDC stage
req_data  in  1+ADDR_WIDTH+DATA_WIDTH  {wr(MSB), addr, wdata}; valid while req_valid=1
sys_addr  out  ADDR_WIDTH  system bus address
sys_wr  out  1  one-cycle write strobe
sys_rd  out  1  one-cycle read strobe
sys_wr_data  out  DATA_WIDTH  system bus write data
sys_rd_data  in  DATA_WIDTH  system bus read data
rsp_req  out  1  one-cycle read-complete pulse, toward the return CDC stage
rsp_data  out  DATA_WIDTH  read data; held until the next read completes
busy  out  1  1 when the FSM is not IDLE or the FIFO is non-empty
overflow  out  1  sticky flag: a request was dropped

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO emptied; FSM in IDLE; overflow cleared. Reset only. An in-flight read is abandoned and produces no rsp_req.
- FIFO: synchronous, FIFO_DEPTH entries, pointers wrap modulo FIFO_DEPTH, with an explicit count for full/empty.
  - Push occurs when req_valid=1.
  - Push while full, with no pop in the same cycle: request dropped, overflow set to 1.
  - Push and pop in the same cycle while full: both succeed; no overflow.
  - Push while empty: entry is visible the next cycle. There is no bypass.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop; register addr, wdata and wr into sys_addr/sys_wr_data; go to ISSUE.
  - ISSUE (exactly 1 cycle): sys_wr=wr and sys_rd=~wr.
    - Write: go to IDLE.
    - Read: load counter with READ_LATENCY-1; go to WAIT.
  - WAIT: decrement the counter. When counter==0, capture sys_rd_data into rsp_data at that edge and go to RESP.
  - RESP (exactly 1 cycle): rsp_req=1; go to IDLE.
- Timing:
  - req_valid in cycle N with FIFO empty and FSM in IDLE: strobe in cycle N+2.
  - Read strobe in cycle T: sys_rd_data is sampled at the end of cycle T+READ_LATENCY; rsp_req is high in cycle T+READ_LATENCY+1.
- Throughput:
  - Back-to-back writes: one strobe every 2 cycles.
  - Back-to-back reads: one strobe every READ_LATENCY+3 cycles.
- Hold rules:
  - sys_addr and sys_wr_data hold their last values outside ISSUE.
  - sys_wr and sys_rd are never both 1.
- Writes generate no response.
- rsp_data changes only on a read capture.
- The counter is $clog2(READ_LATENCY)+1 bits wide; no wrap-around is possible.

Decomposition:
- Package fmc_sys_pkg:
  - FSM state encoding (IDLE, ISSUE, WAIT, RESP).
  - Request field offsets (WR_BIT = ADDR_WIDTH+DATA_WIDTH) and field-slicing constants.
- Sub-module fmc_req_fifo: parameterized width/depth synchronous FIFO with push, pop, full, empty and count. It uses the same clk/reset_n and exposes no overflow logic; the parent computes overflow from push && full && !pop.

Test Plan:
- Single write: req_valid for one cycle with {1, 16'h0010, 32'hDEADBEEF} in cycle N → sys_wr=1, sys_addr=16'h0010, sys_wr_data=32'hDEADBEEF in cycle N+2 only; rsp_req never asserts; busy returns to 0 at N+3.
- Single read with READ_LATENCY=2: {0, 16'h0004, x} in cycle N; model drives 32'hCAFEF00D at cycle N+4 → sys_rd=1 at N+2; rsp_req=1 at N+5 with rsp_data=32'hCAFEF00D, held afterwards.
- Burst: 5 requests pushed on consecutive cycles with FIFO_DEPTH=4 (3 writes, then 2 reads) → one request popped at N+1, so all 5 are accepted; overflow stays 0; strobes appear in push order; exactly 2 rsp_req pulses.
- Overflow: 6 pushes on consecutive cycles while the FSM is stalled in WAIT with READ_LATENCY=8 → the 5th request is dropped and overflow=1 and stays set; only the first 4 buffered requests are issued after the read.
- Simultaneous push/pop at full: FIFO full in IDLE, req_valid in the pop cycle → count stays 4; no overflow; the new entry is issued last.
- Reset mid-read: assert reset_n=0 during WAIT → all outputs 0 immediately; after release no rsp_req, busy=0, and a new request behaves as in scenario 2.
